// File: rtl/fill_pump_controller_pkg.sv
// Shared state and fault-code encodings for the tank fill pump controller.
// The display path decodes state_out and fault_code with these same values.
package fill_pump_controller_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_FILLING  = 3'd2,
    ST_COOLDOWN = 3'd3,
    ST_FAULT    = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    FC_NONE    = 2'b00,
    FC_SENSOR  = 2'b01,
    FC_TIMEOUT = 2'b10,
    FC_CONFIG  = 2'b11
  } fault_code_t;

endpackage

// File: rtl/fill_pump_controller_tick_counter.sv
// Saturating seconds counter: synchronous clear wins over the tick enable,
// and the count sticks at all-ones instead of wrapping.
module tick_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         en,
  output logic [W-1:0] count
);

  // Count ticks, clear on request, hold at the maximum value.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/fill_pump_controller.sv
// Tank fill pump sequencer: persistence-filtered level flags, fill timeout,
// minimum off time after any stop, and a latched fault cleared by acknowledge.
module fill_pump_controller
  import fill_pump_controller_pkg::*;
#(
  parameter int CNT_W      = 8,
  parameter int CONFIRM_S  = 3,
  parameter int MAX_FILL_S = 120,
  parameter int MIN_OFF_S  = 10
) (
  input  logic             clk_100MHz,
  input  logic             reset,
  input  logic             tick_1Hz,
  input  logic             GOET,
  input  logic             LOET,
  input  logic             input_error,
  input  logic             ack_button,
  output logic             pump_on,
  output logic             fault,
  output logic [1:0]       fault_code,
  output logic [2:0]       state_out,
  output logic [CNT_W-1:0] fill_seconds
);

  // Comparison points: the action fires on the tick that completes the interval.
  localparam logic [CNT_W-1:0] CONFIRM_LAST = CNT_W'(CONFIRM_S - 1);
  localparam logic [CNT_W-1:0] FILL_LAST    = CNT_W'(MAX_FILL_S - 1);
  localparam logic [CNT_W-1:0] OFF_LAST     = CNT_W'(MIN_OFF_S - 1);

  state_t            state, next_state;
  fault_code_t       code_q, next_code;
  logic [CNT_W-1:0]  pcnt, off_cnt;
  logic              watch_flag, confirmed, level_conflict;
  logic              pcnt_clear, fill_clear, fill_en, off_clear;

  // High threshold below low threshold: both comparators assert together.
  assign level_conflict = GOET & LOET;

  // LOET is watched while arming, GOET while filling.
  assign watch_flag = (state == ST_FILLING) ? GOET : LOET;
  assign confirmed  = tick_1Hz && watch_flag && (pcnt == CONFIRM_LAST);

  // Next-state and fault-code selection, global error priority applied last.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    next_code  = code_q;
    case (state)
      ST_IDLE: begin
        if (LOET) next_state = ST_ARM;
      end
      ST_ARM: begin
        if (!LOET)          next_state = ST_IDLE;
        else if (confirmed) next_state = ST_FILLING;
      end
      ST_FILLING: begin
        // A confirmed full level beats a timeout landing on the same tick.
        if (confirmed) begin
          next_state = ST_COOLDOWN;
        end else if (tick_1Hz && (fill_seconds == FILL_LAST)) begin
          next_state = ST_FAULT;
          next_code  = FC_TIMEOUT;
        end
      end
      ST_COOLDOWN: begin
        if (tick_1Hz && (off_cnt == OFF_LAST)) next_state = ST_IDLE;
      end
      ST_FAULT: begin
        if (ack_button && !input_error && !level_conflict) begin
          next_state = ST_COOLDOWN;
          next_code  = FC_NONE;
        end
      end
      default: begin
        next_state = ST_IDLE;
        next_code  = FC_NONE;
      end
    endcase
    // Sensor and threshold faults act immediately from any non-fault state.
    if (state != ST_FAULT) begin
      if (input_error) begin
        next_state = ST_FAULT;
        next_code  = FC_SENSOR;
      end else if (level_conflict) begin
        next_state = ST_FAULT;
        next_code  = FC_CONFIG;
      end
    end
  end

  // Persistence restarts whenever the watched flag drops or the state changes.
  assign pcnt_clear = !watch_flag || (next_state != state) ||
                      !((state == ST_ARM) || (state == ST_FILLING));
  assign fill_clear = (next_state == ST_FILLING) && (state != ST_FILLING);
  assign fill_en    = tick_1Hz && (state == ST_FILLING);
  assign off_clear  = (state != ST_COOLDOWN);

  tick_counter #(.W(CNT_W)) u_pcnt (
    .clk(clk_100MHz), .rst(reset), .clear(pcnt_clear), .en(tick_1Hz), .count(pcnt)
  );

  tick_counter #(.W(CNT_W)) u_fill (
    .clk(clk_100MHz), .rst(reset), .clear(fill_clear), .en(fill_en), .count(fill_seconds)
  );

  tick_counter #(.W(CNT_W)) u_off (
    .clk(clk_100MHz), .rst(reset), .clear(off_clear), .en(tick_1Hz), .count(off_cnt)
  );

  // State, latched fault code and registered pump drive.
  always_ff @(posedge clk_100MHz or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      code_q  <= FC_NONE;
      pump_on <= 1'b0;
    end else begin
      state   <= next_state;
      code_q  <= next_code;
      pump_on <= (state == ST_FILLING);
    end
  end

  assign fault      = (state == ST_FAULT);
  assign fault_code = code_q;
  assign state_out  = state;

endmodule

// File: tb/tb_fill_pump_controller.sv
// Directed bench for fill_pump_controller: default instance plus a
// CONFIRM_S=1 / MAX_FILL_S=1 instance for the same-tick priority case.
module tb_fill_pump_controller;

  logic       clk_100MHz = 1'b0;
  logic       reset;
  logic       tick_1Hz, GOET, LOET, input_error, ack_button;
  logic       pump_on, fault, pump_on6, fault6;
  logic [1:0] fault_code, fault_code6;
  logic [2:0] state_out, state_out6;
  logic [7:0] fill_seconds, fill_seconds6;

  int checks = 0;
  int errors = 0;

  always #5 clk_100MHz = ~clk_100MHz;

  fill_pump_controller dut (
    .clk_100MHz(clk_100MHz), .reset(reset), .tick_1Hz(tick_1Hz),
    .GOET(GOET), .LOET(LOET), .input_error(input_error), .ack_button(ack_button),
    .pump_on(pump_on), .fault(fault), .fault_code(fault_code),
    .state_out(state_out), .fill_seconds(fill_seconds)
  );

  fill_pump_controller #(.CNT_W(8), .CONFIRM_S(1), .MAX_FILL_S(1), .MIN_OFF_S(10)) dut6 (
    .clk_100MHz(clk_100MHz), .reset(reset), .tick_1Hz(tick_1Hz),
    .GOET(GOET), .LOET(LOET), .input_error(input_error), .ack_button(ack_button),
    .pump_on(pump_on6), .fault(fault6), .fault_code(fault_code6),
    .state_out(state_out6), .fill_seconds(fill_seconds6)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // One clock, then sample 1 ns after the edge.
  task automatic cyc();
    @(posedge clk_100MHz);
    #1;
  endtask

  task automatic tick();
    tick_1Hz = 1'b1;
    cyc();
    tick_1Hz = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic ack();
    ack_button = 1'b1;
    cyc();
    ack_button = 1'b0;
  endtask

  initial begin
    reset = 1'b1; tick_1Hz = 1'b0; GOET = 1'b0; LOET = 1'b0;
    input_error = 1'b0; ack_button = 1'b0;
    cyc(); cyc();
    check("rst_state", state_out, 0);
    check("rst_pump", pump_on, 0);
    check("rst_fault", fault, 0);
    check("rst_code", fault_code, 0);
    check("rst_fill", fill_seconds, 0);
    reset = 1'b0;
    cyc();

    // 1: normal fill and cooldown
    LOET = 1'b1; cyc();
    check("t1_arm", state_out, 1);
    ticks(2);
    check("t1_arm_hold", state_out, 1);
    tick();
    check("t1_filling", state_out, 2);
    check("t1_pump_lag", pump_on, 0);
    cyc();
    check("t1_pump_on", pump_on, 1);
    LOET = 1'b0; GOET = 1'b1;
    ticks(2);
    check("t1_goet_wait", state_out, 2);
    tick();
    check("t1_cooldown", state_out, 3);
    check("t1_fill_sec", fill_seconds, 3);
    cyc();
    check("t1_pump_off", pump_on, 0);
    GOET = 1'b0;
    ticks(9);
    check("t1_cool_hold", state_out, 3);
    tick();
    check("t1_idle", state_out, 0);
    check("t1_fill_hold", fill_seconds, 3);

    // 2: interrupted arming restarts persistence
    LOET = 1'b1; cyc();
    ticks(2);
    LOET = 1'b0; cyc();
    check("t2_drop_idle", state_out, 0);
    LOET = 1'b1; cyc();
    ticks(2);
    check("t2_restart", state_out, 1);
    tick();
    check("t2_filling", state_out, 2);
    check("t2_fill_clr", fill_seconds, 0);

    // 3: fill timeout
    LOET = 1'b0;
    ticks(119);
    check("t3_pre_timeout", state_out, 2);
    check("t3_fill_119", fill_seconds, 119);
    tick();
    check("t3_fault_state", state_out, 4);
    check("t3_code", fault_code, 2);
    check("t3_fault", fault, 1);
    check("t3_fill_120", fill_seconds, 120);
    cyc();
    check("t3_pump_off", pump_on, 0);
    ack();
    check("t3_ack_cool", state_out, 3);
    check("t3_code_clr", fault_code, 0);
    check("t3_fault_clr", fault, 0);
    ticks(10);
    check("t3_idle", state_out, 0);

    // 4: sensor error mid-fill
    LOET = 1'b1; cyc();
    ticks(3);
    cyc();
    check("t4_pump_on", pump_on, 1);
    LOET = 1'b0;
    ticks(2);
    input_error = 1'b1; cyc();
    check("t4_fault", state_out, 4);
    check("t4_code", fault_code, 1);
    cyc();
    check("t4_pump_off", pump_on, 0);
    ack();
    check("t4_ack_ignored", state_out, 4);
    input_error = 1'b0; GOET = 1'b1; LOET = 1'b1; cyc();
    check("t4_code_kept", fault_code, 1);
    GOET = 1'b0; LOET = 1'b0; cyc();
    ack();
    check("t4_ack_cool", state_out, 3);
    ticks(10);
    check("t4_idle", state_out, 0);

    // 5: threshold config fault, then async reset mid-fill
    GOET = 1'b1; LOET = 1'b1; cyc();
    check("t5_cfg_fault", state_out, 4);
    check("t5_cfg_code", fault_code, 3);
    GOET = 1'b0; LOET = 1'b0;
    ack();
    ticks(10);
    check("t5_idle", state_out, 0);
    LOET = 1'b1; cyc();
    ticks(3);
    cyc();
    check("t5_pump_on", pump_on, 1);
    #2 reset = 1'b1;
    #1;
    check("t5_async_pump", pump_on, 0);
    check("t5_async_state", state_out, 0);
    LOET = 1'b0;
    cyc();
    reset = 1'b0;
    cyc();

    // 6: same-tick confirm and timeout in the short-parameter instance
    LOET = 1'b1; cyc();
    check("t6_arm", state_out6, 1);
    tick();
    check("t6_filling", state_out6, 2);
    LOET = 1'b0; GOET = 1'b1;
    tick();
    check("t6_goet_wins", state_out6, 3);
    check("t6_no_fault", fault6, 0);
    check("t6_fill_1", fill_seconds6, 1);
    GOET = 1'b0;
    cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
